sync_fifo_flex: RTL
===================

Name: sync_fifo_flex

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds selectable standard/first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty flags, an occupancy count, a read-data-valid strobe and sticky overflow/underflow error flags.
- Used between streaming blocks in a single clock domain, for example pixel and line buffering, and for elastic buffering in front of a UART or DDR bridge.
- Storage is an inferred simple dual-port RAM of depth 2**ADDR_WIDTH with a registered read port.

Parameters:
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 2..16.
- DATA_WIDTH, 8: word width in bits.
- FWFT, 0: read mode. 0 = standard; 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: wr_almost_full asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 2: rd_almost_empty asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  Single clock. All logic is on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- wr_en  in  1  Write request.
- wr_data  in  DATA_WIDTH  Write data.
- wr_full  out  1  High when count == DEPTH.
- wr_almost_full  out  1  High when count >= AFULL_TH.
- rd_en  in  1  Read request (standard mode) or pop/acknowledge (FWFT mode).
- rd_data  out  DATA_WIDTH  Read data.
- rd_valid  out  1  Standard mode: one-cycle pulse marking rd_data valid. FWFT mode: equal to ~rd_empty.
- rd_empty  out  1  No word available to the reader.
- rd_almost_empty  out  1  High when count <= AEMPTY_TH.
- data_count  out  ADDR_WIDTH+1  Words written and not yet popped, range 0..DEPTH.
- overflow  out  1  Sticky flag: a write was attempted while full.
- underflow  out  1  Sticky flag: a read was attempted while empty.

Behaviour:
- Reset (rst high at a clock edge) applies to all of the following:
  - Pointers and count go to 0.
  - wr_full=0, wr_almost_full=(AFULL_TH==0 ? 1 : 0), rd_empty=1, rd_almost_empty=1, rd_valid=0, overflow=0, underflow=0, rd_data=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored data. The first post-reset write behaves as a write into an empty FIFO.
- Pointers are ADDR_WIDTH+1 bits and use the extra MSB for wrap. The RAM is addressed with the low ADDR_WIDTH bits. Wrap from DEPTH-1 to 0 must be seamless.
- Write acceptance: wr_acc = wr_en & ~wr_full.
  - wr_en while full: the write is dropped, storage is unchanged and overflow is set.
- Standard-mode read acceptance: rd_acc = rd_en & ~rd_empty.
  - rd_en while empty: no pointer change and underflow is set.
- data_count update: +1 on wr_acc only, -1 on pop only, unchanged when both occur in the same cycle.
- Status flags (wr_full, wr_almost_full, rd_almost_empty) are decoded from the registered count only. They add no latency and are valid the cycle after the causing edge.
- Simultaneous write and read:
  - Full FIFO: only the read is accepted; overflow sets; count goes to DEPTH-1.
  - Empty FIFO: only the write is accepted; underflow sets (standard mode).
- Standard mode (FWFT=0):
  - rd_empty = (count == 0).
  - A read accepted at edge N gives rd_data = head word and rd_valid=1 after edge N+1, i.e. one-cycle latency.
  - rd_data holds its value when no read is accepted.
  - A word written at edge N is readable from the cycle after edge N; rd_empty falls after N.
- FWFT mode (FWFT=1):
  - An output-stage valid bit, ov, drives rd_empty = ~ov and rd_valid = ov.
  - When ov=1, rd_data presents the head word without any rd_en.
  - Pop = rd_en & ov. rd_en while ov=0 sets underflow.
  - Prefetch FSM, state = {ov, RAM-read-in-flight}:
    - IDLE: ov=0, none in flight. If the RAM holds a word, issue a RAM read and go to FETCH.
    - FETCH: the RAM read lands in the output register; ov=1; go to VALID.
    - VALID: on a pop with another word in RAM, issue a RAM read the same cycle so that back-to-back pops sustain 1 word/clk. On a pop with the RAM empty, go to IDLE.
  - Latency: a word written into an empty FIFO at edge N gives rd_empty=0 and rd_data=word after edge N+2.
  - data_count includes the word in the output stage. count can therefore be 1 while rd_empty=1, for the two cycles described above.
  - wr_full still asserts at count == DEPTH.
- overflow and underflow are cleared only by rst.
- No combinational path from rd_en or wr_en to any output.

Test Plan:
1. ADDR_WIDTH=4, FWFT=0: write 16 words 0x00..0x0F, with a further wr_en attempt on the 17th cycle → wr_full=1 and data_count=16 after the 16th write; overflow=1 after the 17th attempt. Then read 16 → rd_data 0x00..0x0F, each with a one-cycle-late rd_valid pulse; rd_empty=1 at the end; count=0.
2. AFULL_TH=14, AEMPTY_TH=2: fill one word at a time → rd_almost_empty drops when count becomes 3; wr_almost_full rises when count becomes 14. Drain → the reverse transitions occur at the same counts.
3. Simultaneous write and read at count=5 for 40 cycles (pointers wrap twice) → count stays 5 and output order is preserved. Simultaneous write and read at full → count=15, overflow=1. Simultaneous write and read at empty → count=1, underflow=1.
4. FWFT=1: write 0xA5 at edge N into an empty FIFO → rd_empty=0 and rd_data=0xA5 after N+2, with no rd_en. Then write 8 more words and hold rd_en high → one pop per clock with no bubbles; rd_empty=1 after the last pop.
5. Assert rst with count=9 mid-stream (both modes) → all outputs at reset values the next cycle. A new write 0x3C then reads back 0x3C and no stale data appears.
6. rd_en on an empty FIFO for 3 cycles → no pointer movement; underflow=1 and remaining 1 until rst.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost-full/almost-empty thresholds, occupancy count,
// read-valid strobe and sticky overflow/underflow flags.
//
// Both modes read the RAM through two register stages: the RAM read
// register (ram_q) and the output register (rd_data).
//
// FWFT prefetch FSM, encoded as {ov, ram_q holds an in-flight word}:
//   state       | meaning
//   S_IDLE      | output empty, nothing in flight; issue a RAM read if a word is stored
//   S_FETCH     | output empty, word in flight; it moves to the output next edge
//   S_VALID     | output holds the head word, nothing prefetched
//   S_VALID_PF  | output holds the head word, next word already prefetched in ram_q
module sync_fifo_flex #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FWFT       = 0,
   parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_full,
   output logic                  wr_almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] ram_q;
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  wr_acc;
   logic                  pop;
   logic                  rd_issue;
   logic                  out_load;
   logic                  empty_i;

   // flags are pure decodes of the registered count
   assign wr_full         = (count == DEPTH_C);
   assign wr_almost_full  = (count >= AFULL_C);
   assign rd_almost_empty = (count <= AEMPTY_C);
   assign data_count      = count;
   assign rd_empty        = empty_i;
   assign wr_acc          = wr_en & ~wr_full;

   // RAM write port and registered read port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
      if (rd_issue) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
   end

   // pointers, occupancy, output register and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_data   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc)   wr_ptr  <= wr_ptr + 1'b1;
         if (rd_issue) rd_ptr  <= rd_ptr + 1'b1;
         if (out_load) rd_data <= ram_q;
         if (wr_acc & ~pop)      count <= count + 1'b1;
         else if (pop & ~wr_acc) count <= count - 1'b1;
         if (wr_en & wr_full)    overflow  <= 1'b1;
         if (rd_en & empty_i)    underflow <= 1'b1;
      end
   end

   if (FWFT != 0) begin : g_fwft
      typedef enum logic [1:0] {
         S_IDLE     = 2'b00,
         S_FETCH    = 2'b01,
         S_VALID    = 2'b10,
         S_VALID_PF = 2'b11
      } state_t;

      state_t state;
      state_t state_nxt;
      logic   ov;
      logic   ram_avail;

      assign ov        = state[1];
      assign ram_avail = (wr_ptr != rd_ptr);
      assign empty_i   = ~ov;
      assign pop       = rd_en & ov;
      assign rd_valid  = ov;

      // prefetch state register
      always_ff @(posedge clk) begin
         if (rst) state <= S_IDLE;
         else     state <= state_nxt;
      end

      // next state, RAM read issue and output-stage load
      always_comb begin
         state_nxt = state;
         rd_issue  = 1'b0;
         out_load  = 1'b0;
         case (state)
            S_IDLE: begin
               if (ram_avail) begin
                  rd_issue  = 1'b1;
                  state_nxt = S_FETCH;
               end
            end
            S_FETCH: begin
               out_load  = 1'b1;
               rd_issue  = ram_avail;
               state_nxt = ram_avail ? S_VALID_PF : S_VALID;
            end
            S_VALID: begin
               rd_issue = ram_avail;
               if (pop) state_nxt = ram_avail ? S_FETCH : S_IDLE;
               else     state_nxt = ram_avail ? S_VALID_PF : S_VALID;
            end
            S_VALID_PF: begin
               if (pop) begin
                  out_load  = 1'b1;
                  rd_issue  = ram_avail;
                  state_nxt = ram_avail ? S_VALID_PF : S_VALID;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end else begin : g_std
      logic issue_d;
      logic valid_q;

      assign empty_i  = (count == '0);
      assign pop      = rd_en & ~empty_i;
      assign rd_issue = pop;
      assign out_load = issue_d;
      assign rd_valid = valid_q;

      // read pipeline: RAM register then output register, valid follows data
      always_ff @(posedge clk) begin
         if (rst) begin
            issue_d <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            issue_d <= rd_issue;
            valid_q <= issue_d;
         end
      end
   end

endmodule
